q_shift_unit: RTL

Q_SHIFT_UNIT -- requirements
Module: q_shift_unit

---
 rtl/q_shift_pkg.sv | 26 ++
 rtl/q_shift_unit_step.sv | 51 +++++
 rtl/q_shift_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/q_shift_pkg.sv
// Shared definitions for the sequential shift unit: op codes, FSM encoding,
// and a helper that tells shifting ops apart from HOLD/LOAD.
package q_shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_SHR_IN = 3'd1,
    OP_SHL    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_LSR    = 3'd4,
    OP_ROR    = 3'd5,
    OP_ROL    = 3'd6,
    OP_ASR    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input op_e o);
    return (o != OP_HOLD) && (o != OP_LOAD);
  endfunction

endpackage

// File: rtl/q_shift_unit_step.sv
// One single-bit step of the shift unit; purely combinational.
// HOLD and LOAD pass the register through, LOAD is applied by the parent.
module q_shift_step
  import q_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             q1_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] d_o,
  output logic             q1_o
);

  always_comb begin
    d_o  = d_i;
    q1_o = q1_i;
    unique case (op_i)
      OP_HOLD, OP_LOAD: begin
        d_o  = d_i;
        q1_o = q1_i;
      end
      OP_SHR_IN: begin
        d_o  = {ser_i, d_i[WIDTH-1:1]};
        q1_o = d_i[0];
      end
      OP_SHL: begin
        d_o  = {d_i[WIDTH-2:0], 1'b0};
        q1_o = 1'b0;
      end
      OP_LSR: begin
        d_o  = {1'b0, d_i[WIDTH-1:1]};
        q1_o = d_i[0];
      end
      OP_ROR: begin
        d_o  = {d_i[0], d_i[WIDTH-1:1]};
        q1_o = 1'b0;
      end
      OP_ROL: begin
        d_o  = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
        q1_o = 1'b0;
      end
      OP_ASR: begin
        d_o  = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
        q1_o = d_i[0];
      end
    endcase
  end

endmodule

// File: rtl/q_shift_unit.sv
// Multi-cycle shift/rotate register: one bit per clock for up to WIDTH steps,
// with a guard bit capturing what falls off the right end.
module q_shift_unit
  import q_shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CW-1:0]    amt,
  input  logic [WIDTH-1:0] in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             q_1,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             q1_q, q1_d;

  op_e              op_in, step_op;
  logic [CW-1:0]    n_eff;
  logic [WIDTH-1:0] step_out;
  logic             step_q1;

  assign op_in   = op_e'(op);
  assign n_eff   = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;
  // The first step happens on the accepting edge, so IDLE uses the live op.
  assign step_op = (state_q == S_RUN) ? op_q : op_in;

  q_shift_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (step_op),
    .d_i   (out_q),
    .q1_i  (q1_q),
    .ser_i (ser_in),
    .d_o   (step_out),
    .q1_o  (step_q1)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (is_shift(op_in) && n_eff > CW'(1)) ? S_RUN : S_DONE;
      S_RUN:  if (cnt_q <= CW'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // cnt holds steps still to run after the current edge's step.
  always_comb begin
    out_d = out_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op_in;
          if (op_in == OP_LOAD) begin
            out_d = in;
            q1_d  = 1'b0;
          end else if (is_shift(op_in) && n_eff != '0) begin
            out_d = step_out;
            q1_d  = step_q1;
            cnt_d = n_eff - CW'(1);
          end
        end
      end
      S_RUN: begin
        out_d = step_out;
        q1_d  = step_q1;
        cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      op_q  <= OP_HOLD;
    end else begin
      out_q <= out_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  assign out = out_q;
  assign q_1 = q1_q;

endmodule
